// File: rtl/wbc_watchdog.sv
// rtl/wbc_watchdog.sv - Wishbone classic bus-timeout guard
// Passes requests through; aborts the slave cycle with a one-cycle ERR after TIMEOUT stalled cycles.
module wbc_watchdog #(
   parameter int AW        = 12,
   parameter int DW        = 32,
   parameter int LGTIMEOUT = 8,
   parameter int TIMEOUT   = 200
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_scyc,
   input  logic              i_sstb,
   input  logic              i_swe,
   input  logic [AW-1:0]     i_saddr,
   input  logic [DW-1:0]     i_sdata,
   input  logic [DW/8-1:0]   i_ssel,
   input  logic [2:0]        i_scti,
   input  logic [1:0]        i_sbte,
   output logic              o_sack,
   output logic              o_serr,
   output logic [DW-1:0]     o_sdata,
   output logic              o_mcyc,
   output logic              o_mstb,
   output logic              o_mwe,
   output logic [AW-1:0]     o_maddr,
   output logic [DW-1:0]     o_mdata,
   output logic [DW/8-1:0]   o_msel,
   output logic [2:0]        o_mcti,
   output logic [1:0]        o_mbte,
   input  logic              i_mack,
   input  logic              i_merr,
   input  logic [DW-1:0]     i_mdata,
   output logic              o_timeout,
   output logic [15:0]       o_ntimeouts
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_ABORT = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   localparam logic [LGTIMEOUT-1:0] CNT_LAST = LGTIMEOUT'(TIMEOUT - 1);
   localparam logic [LGTIMEOUT-1:0] CNT_ONE  = LGTIMEOUT'(1);

   state_t               state_q, state_d;
   logic [LGTIMEOUT-1:0] cnt_q, cnt_d;
   logic                 timeout_q, timeout_d;
   logic [15:0]          ntimeouts_q, ntimeouts_d;

   logic pend, resp, gated;

   assign pend = i_scyc & i_sstb;
   assign resp = i_mack | i_merr;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ntimeouts_d = ntimeouts_q;
      case (state_q)
         S_IDLE: begin
            if (pend && !resp) begin
               state_d = S_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         S_WAIT: begin
            // A response in the last cycle wins over the abort.
            if (!pend || resp) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_ABORT;
               cnt_d   = '0;
               if (ntimeouts_q != 16'hFFFF)
                  ntimeouts_d = ntimeouts_q + 16'd1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_ABORT: state_d = pend ? S_HOLD : S_IDLE;
         S_HOLD: begin
            if (!pend)
               state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      timeout_d = (state_d == S_ABORT);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
         ntimeouts_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
         ntimeouts_q <= ntimeouts_d;
      end
   end

   // The slave is cut off from the abort cycle until the bridge drops its strobe.
   assign gated = (state_q == S_ABORT) || (state_q == S_HOLD);

   assign o_mcyc  = i_reset_n & ~gated & i_scyc;
   assign o_mstb  = i_reset_n & ~gated & i_sstb;
   assign o_mwe   = i_swe;
   assign o_maddr = i_saddr;
   assign o_mdata = i_sdata;
   assign o_msel  = i_ssel;
   assign o_mcti  = i_scti;
   assign o_mbte  = i_sbte;

   assign o_sack  = i_reset_n & ~gated & i_scyc & i_mack;
   assign o_serr  = i_reset_n & (gated ? (state_q == S_ABORT) : (i_scyc & i_merr));
   assign o_sdata = i_mdata;

   assign o_timeout   = timeout_q;
   assign o_ntimeouts = ntimeouts_q;

endmodule

// File: tb/tb_wbc_watchdog.sv
// tb/tb_wbc_watchdog.sv - randomized self-checking bench for wbc_watchdog
// Reference model tracks consecutive unanswered strobe cycles and the post-abort hold.
module tb_wbc_watchdog;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int TO = 8;

   logic            i_clk = 1'b0;
   logic            i_reset_n = 1'b0;
   logic            i_scyc = 1'b0, i_sstb = 1'b0, i_swe = 1'b0;
   logic [AW-1:0]   i_saddr = '0;
   logic [DW-1:0]   i_sdata = '0;
   logic [DW/8-1:0] i_ssel = '0;
   logic [2:0]      i_scti = '0;
   logic [1:0]      i_sbte = '0;
   logic            o_sack, o_serr;
   logic [DW-1:0]   o_sdata;
   logic            o_mcyc, o_mstb, o_mwe;
   logic [AW-1:0]   o_maddr;
   logic [DW-1:0]   o_mdata;
   logic [DW/8-1:0] o_msel;
   logic [2:0]      o_mcti;
   logic [1:0]      o_mbte;
   logic            i_mack = 1'b0, i_merr = 1'b0;
   logic [DW-1:0]   i_mdata = '0;
   logic            o_timeout;
   logic [15:0]     o_ntimeouts;

   wbc_watchdog #(.AW(AW), .DW(DW), .LGTIMEOUT(8), .TIMEOUT(TO)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_scyc(i_scyc), .i_sstb(i_sstb), .i_swe(i_swe),
      .i_saddr(i_saddr), .i_sdata(i_sdata), .i_ssel(i_ssel),
      .i_scti(i_scti), .i_sbte(i_sbte),
      .o_sack(o_sack), .o_serr(o_serr), .o_sdata(o_sdata),
      .o_mcyc(o_mcyc), .o_mstb(o_mstb), .o_mwe(o_mwe),
      .o_maddr(o_maddr), .o_mdata(o_mdata), .o_msel(o_msel),
      .o_mcti(o_mcti), .o_mbte(o_mbte),
      .i_mack(i_mack), .i_merr(i_merr), .i_mdata(i_mdata),
      .o_timeout(o_timeout), .o_ntimeouts(o_ntimeouts)
   );

   always #5 i_clk = ~i_clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int stall_run = 0;
   bit abort_now = 1'b0;
   bit holding   = 1'b0;
   int nto       = 0;
   int serr_seen = 0;
   int sack_seen = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 30)
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
      end
   endtask

   task automatic drive(input bit cyc, input bit stb, input bit ack, input bit err, input logic [31:0] md);
      logic [31:0] r;
      i_scyc = cyc; i_sstb = stb; i_mack = ack; i_merr = err;
      i_mdata = md;
      r = $urandom; i_saddr = r[AW-1:0];
      i_sdata = $urandom;
      r = $urandom;
      i_swe = r[0]; i_ssel = r[7:4]; i_scti = r[10:8]; i_sbte = r[13:12];
   endtask

   task automatic step(input bit cyc, input bit stb, input bit ack, input bit err);
      bit blocked, pend, resp;
      logic [31:0] md;
      md = $urandom;
      @(negedge i_clk);
      drive(cyc, stb, ack, err, md);
      #1;
      blocked = abort_now | holding;
      chk("mcyc",  o_mcyc,  32'(!blocked & cyc));
      chk("mstb",  o_mstb,  32'(!blocked & stb));
      chk("sack",  o_sack,  32'(!blocked & cyc & ack));
      chk("serr",  o_serr,  32'(abort_now | (!blocked & cyc & err)));
      chk("tmo",   o_timeout, 32'(abort_now));
      chk("ntmo",  o_ntimeouts, 32'(nto));
      chk("sdata", o_sdata, md);
      chk("maddr", o_maddr, 32'(i_saddr));
      chk("mwe",   o_mwe,   32'(i_swe));
      if (o_serr) serr_seen++;
      if (o_sack) sack_seen++;
      @(posedge i_clk);
      pend = cyc & stb;
      resp = ack | err;
      if (blocked) begin
         holding   = pend;
         abort_now = 1'b0;
         stall_run = 0;
      end else if (pend && !resp) begin
         stall_run++;
      end else begin
         stall_run = 0;
      end
      // TO consecutive unanswered cycles earn an ERR in the next cycle.
      if (stall_run == TO) begin
         abort_now = 1'b1;
         stall_run = 0;
         if (nto < 65535) nto++;
      end
   endtask

   task automatic reset_pulse(input bit cyc, input bit stb, input bit ack);
      @(negedge i_clk);
      drive(cyc, stb, ack, 1'b1, 32'h1234_5678);
      i_reset_n = 1'b0;
      #1;
      chk("rst_mcyc", o_mcyc, 0);
      chk("rst_mstb", o_mstb, 0);
      chk("rst_sack", o_sack, 0);
      chk("rst_serr", o_serr, 0);
      chk("rst_tmo",  o_timeout, 0);
      chk("rst_ntmo", o_ntimeouts, 0);
      chk("rst_maddr", o_maddr, 32'(i_saddr));
      chk("rst_sdata", o_sdata, 32'h1234_5678);
      @(posedge i_clk);
      stall_run = 0; abort_now = 1'b0; holding = 1'b0; nto = 0;
      @(negedge i_clk);
      i_reset_n = 1'b1;
   endtask

   initial begin
      int pct;
      reset_pulse(1'b1, 1'b1, 1'b1);
      step(0, 0, 0, 0);

      // Read acked in cycle 3
      serr_seen = 0; sack_seen = 0;
      repeat (3) step(1, 1, 0, 0);
      @(negedge i_clk);
      drive(1, 1, 1, 0, 32'hDEADBEEF);
      #1;
      chk("s1_sack", o_sack, 1);
      chk("s1_sdata", o_sdata, 32'hDEADBEEF);
      @(posedge i_clk);
      stall_run = 0;
      step(0, 0, 0, 0);
      chk("s1_serr_count", serr_seen, 0);
      chk("s1_ntmo", o_ntimeouts, 0);

      // Dead slave, strobe held one cycle past ERR
      serr_seen = 0;
      repeat (8) step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      chk("s2_serr_count", serr_seen, 1);
      chk("s2_ntmo", o_ntimeouts, 1);

      // Ack in the very last cycle beats the abort
      serr_seen = 0;
      repeat (7) step(1, 1, 0, 0);
      step(1, 1, 1, 0);
      step(0, 0, 0, 0);
      chk("s3_serr_count", serr_seen, 0);
      chk("s3_ntmo", o_ntimeouts, 1);

      // Late ack during abort/hold is dropped
      sack_seen = 0;
      repeat (8) step(1, 1, 0, 0);
      step(1, 1, 1, 0);
      step(1, 1, 1, 0);
      step(0, 0, 0, 0);
      chk("s4_sack_count", sack_seen, 0);
      step(1, 1, 1, 0);
      chk("s4_sack_after", sack_seen, 1);

      // Upstream drops cyc mid-wait, then a fresh request gets a full window
      serr_seen = 0;
      repeat (4) step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("s5_serr_early", serr_seen, 0);
      repeat (8) step(1, 1, 0, 0);
      chk("s5_serr_window", serr_seen, 0);
      step(0, 1, 0, 0);
      chk("s5_serr_late", serr_seen, 1);

      // Four timeouts, then reset in the middle of a wait
      repeat (4) begin
         repeat (8) step(1, 1, 0, 0);
         step(0, 0, 0, 0);
      end
      chk("s6_ntmo", o_ntimeouts, 7);
      repeat (3) step(1, 1, 0, 0);
      reset_pulse(1'b1, 1'b1, 1'b0);
      serr_seen = 0;
      step(0, 0, 0, 0);
      chk("s6_serr_after", serr_seen, 0);
      chk("s6_ntmo_after", o_ntimeouts, 0);

      // Randomized traffic with varying slave responsiveness
      for (int seg = 0; seg < 40; seg++) begin
         pct = (seg % 3 == 0) ? 50 : ((seg % 3 == 1) ? 15 : 3);
         for (int c = 0; c < 60; c++) begin
            bit cyc, stb;
            cyc = ($urandom_range(99) < 90);
            stb = cyc ? ($urandom_range(99) < 90) : ($urandom_range(99) < 10);
            step(cyc, stb, $urandom_range(99) < pct, $urandom_range(99) < pct / 3);
         end
         if (seg == 20) reset_pulse(1'b1, 1'b1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wbc_watchdog.md
# wbc_watchdog

Bus-timeout guard for a Wishbone classic link, placed directly downstream of the pipelined-to-classic bridge and directly upstream of the classic slave. All request signals pass through combinationally. Every cycle that a strobe stays outstanding without ACK or ERR is counted. When the count reaches `TIMEOUT`, the block aborts the slave cycle and returns a one-cycle ERR upstream, so a dead slave cannot hang the bridge or the master above it.

## Interface
- `AW`, 12, address width
- `DW`, 32, data width
- `LGTIMEOUT`, 8, width of the wait counter
- `TIMEOUT`, 200, stall cycles before abort; legal range is 2 to 2^LGTIMEOUT−1
- `i_clk`  in  1  clock; all state changes on the rising edge
- `i_reset_n`  in  1  reset; asynchronous assert, active-low
- `i_scyc`, `i_sstb`, `i_swe`  in  1 each  classic request from the bridge
- `i_saddr`  in  AW  address
- `i_sdata`  in  DW  write data
- `i_ssel`  in  DW/8  byte selects
- `i_scti`  in  3  cycle type
- `i_sbte`  in  2  burst type
- `o_sack`, `o_serr`  out  1 each  response to the bridge
- `o_sdata`  out  DW  read data to the bridge
- `o_mcyc`, `o_mstb`, `o_mwe`  out  1 each  classic request to the slave
- `o_maddr`  out  AW  address to the slave
- `o_mdata`  out  DW  write data to the slave
- `o_msel`  out  DW/8  byte selects to the slave
- `o_mcti`  out  3  cycle type to the slave
- `o_mbte`  out  2  burst type to the slave
- `i_mack`, `i_merr`  in  1 each  slave response
- `i_mdata`  in  DW  slave read data
- `o_timeout`  out  1  registered one-cycle pulse, high in the ABORT cycle
- `o_ntimeouts`  out  16  saturating count of aborts since reset

## Operation
- States:
  - IDLE: no strobe outstanding
  - WAIT: strobe outstanding, counter running
  - ABORT: one cycle, ERR returned upstream
  - HOLD: waiting for the upstream strobe to drop after an abort
- Pass-through (in IDLE and WAIT):
  - `o_mcyc`/`o_mstb`/`o_mwe`/`o_maddr`/`o_mdata`/`o_msel`/`o_mcti`/`o_mbte` copy the `i_s*` inputs.
  - `o_sack = i_scyc & i_mack`; `o_serr = i_scyc & i_merr`.
- `o_sdata = i_mdata` in all states.
- Gating (in ABORT and HOLD):
  - `o_mcyc = o_mstb = 0`.
  - `o_sack = 0`, so a late `i_mack` is ignored.
  - `o_serr = 1` in ABORT only; 0 in HOLD.
- Transitions:
  - IDLE → WAIT when `i_scyc & i_sstb & !i_mack & !i_merr`; `cnt` ← 1.
  - WAIT → IDLE when `!i_scyc | !i_sstb | i_mack | i_merr`; `cnt` ← 0.
  - WAIT → ABORT when none of the above and `cnt == TIMEOUT-1`.
  - Otherwise WAIT stays, `cnt` ← `cnt+1`.
  - ABORT → IDLE when `!i_sstb | !i_scyc`, else ABORT → HOLD.
  - HOLD → IDLE when `!i_sstb | !i_scyc`.
- `o_ntimeouts` increments on entry to ABORT and saturates at 0xFFFF.
- The counter is LGTIMEOUT bits and never wraps, because it is cleared or the state leaves WAIT before overflow.

## Timing
- Zero-cycle forward latency in IDLE/WAIT: request and response paths are combinational.
- Abort latency: a strobe first presented in cycle 0 with no response yields `o_serr = 1` in cycle `TIMEOUT`, with `o_mcyc = 0` in that same cycle.
- Simultaneous `i_mack` and `cnt == TIMEOUT-1`: the ACK wins. It is forwarded, the state goes to IDLE, and no abort occurs.
- Simultaneous `i_mack` and `i_merr`: both are forwarded unchanged.
- Upstream drops `i_scyc` in WAIT: the state returns to IDLE the next edge and `cnt` clears. No ERR is generated.
- A strobe that is answered in its first cycle never leaves IDLE.
- Reset (`i_reset_n` low, asynchronous):
  - Immediately: state = IDLE, `cnt` = 0, `o_timeout` = 0, `o_ntimeouts` = 0.
  - While reset is held: `o_mcyc`, `o_mstb`, `o_sack`, `o_serr` are forced 0.
  - All other pass-through outputs follow their inputs.
- Reset asserted mid-WAIT or mid-HOLD: the block returns to IDLE with no ERR pulse.

## Test plan
- Read, slave ACKs 3 cycles after strobe, `TIMEOUT = 8`, `i_mdata = 0xDEADBEEF`:
  - `o_sack` high in cycle 3 with `o_sdata = 0xDEADBEEF`.
  - `o_serr`, `o_timeout` never high; `o_ntimeouts = 0`.
- Slave never responds, `TIMEOUT = 8`, upstream holds strobe 1 extra cycle after ERR:
  - `o_serr` and `o_timeout` high in cycle 8 only.
  - `o_mcyc = 0` in cycles 8–9; the state passes through HOLD to IDLE.
  - `o_ntimeouts = 1`.
- Slave ACKs exactly in cycle 7 with `TIMEOUT = 8`:
  - ACK forwarded; no abort; `o_ntimeouts = 0`.
- Late `i_mack` during ABORT/HOLD:
  - `o_sack` stays 0.
  - The next request is forwarded normally from IDLE.
- Upstream drops `i_scyc` in cycle 4 of WAIT:
  - IDLE next cycle; no `o_serr`.
  - A new request 2 cycles later times out at its own full 8-cycle limit.
- `i_reset_n` pulsed low for one cycle mid-WAIT after 4 prior timeouts:
  - `o_ntimeouts = 0` and `o_mstb = 0` during reset.
  - State IDLE afterwards; no ERR.
